// File: rtl/uart_pkg.sv
// uart_pkg: register map, bit indices, FSM state types and divisor helper for uart_fifo_mmio
package uart_pkg;
    localparam logic [31:0] OFF_DATA   = 32'h000;
    localparam logic [31:0] OFF_CTRL   = 32'h004;
    localparam logic [31:0] OFF_STATUS = 32'h005;
    localparam logic [31:0] OFF_DIV    = 32'h100;

    localparam int CTRL_IE_RX    = 0;
    localparam int CTRL_IE_TX    = 1;
    localparam int CTRL_RX_FLUSH = 2;
    localparam int CTRL_TX_FLUSH = 3;
    localparam int CTRL_LOOPBACK = 4;

    localparam int ST_RX_NE      = 0;
    localparam int ST_RX_OVR     = 1;
    localparam int ST_TX_FULL    = 2;
    localparam int ST_RX_FULL    = 3;
    localparam int ST_TX_DROP    = 4;
    localparam int ST_TX_EMPTY   = 5;
    localparam int ST_TX_BUSY    = 6;
    localparam int ST_FRAME_ERR  = 7;

    localparam logic [31:0] MIN_DIV = 32'd2;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    function automatic logic [31:0] eff_div(input logic [31:0] d);
        return (d < MIN_DIV) ? MIN_DIV : d;
    endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with combinational head, flush, and push-on-full allowed when popping
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd;
    logic [AW-1:0]    r_wr;
    logic [AW:0]      r_cnt;
    logic             w_pop;
    logic             w_push;

    assign empty  = r_cnt == '0;
    assign full   = r_cnt == (AW+1)'(DEPTH);
    assign dout   = r_mem[r_rd];
    assign w_pop  = pop & ~empty;
    assign w_push = push & (~full | w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else if (flush) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop) r_rd <= r_rd + 1'b1;
            r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push & ~flush) r_mem[r_wr] <= din;
    end
endmodule

// File: rtl/uart_fifo_mmio.sv
// uart_fifo_mmio: memory-mapped UART with TX/RX FIFOs, programmable divisor, sticky errors, irq and loopback
module uart_fifo_mmio
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h10010000,
    parameter int          FIFO_DEPTH  = 16,
    parameter logic [31:0] DEFAULT_DIV = 32'd434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic [3:0]  write_mask,
    input  logic        write_enable,
    input  logic        read_enable,
    output logic [31:0] read_data,
    output logic        tx,
    input  logic        rx,
    output logic        irq
);
    logic        w_sel_data, w_sel_ctrl, w_sel_status, w_sel_div;
    logic        w_wr_data, w_wr_ctrl, w_wr_status, w_wr_div;
    logic [7:0]  w_clr, w_status, w_ctrl;
    logic        r_ie_rx, r_ie_tx, r_loopback;
    logic [31:0] r_div;
    logic        r_rx_ovr, r_tx_drop, r_frame_err, r_irq;
    logic [7:0]  w_tx_dout, w_rx_dout;
    logic        w_tx_full, w_tx_empty, w_tx_pop, w_tx_busy;
    logic        w_rx_full, w_rx_empty, w_rx_pop, w_rx_push, w_frame_err_set;

    assign w_sel_data   = address == BASE_ADDR + OFF_DATA;
    assign w_sel_ctrl   = address == BASE_ADDR + OFF_CTRL;
    assign w_sel_status = address == BASE_ADDR + OFF_STATUS;
    assign w_sel_div    = address == BASE_ADDR + OFF_DIV;
    assign w_wr_data    = write_enable & w_sel_data;
    assign w_wr_ctrl    = write_enable & w_sel_ctrl;
    assign w_wr_status  = write_enable & w_sel_status;
    assign w_wr_div     = write_enable & w_sel_div;
    assign w_clr        = {8{w_wr_status}} & write_data[7:0];
    assign w_rx_pop     = read_enable & w_sel_data & ~w_rx_empty;
    assign irq          = r_irq;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst), .push(w_wr_data), .pop(w_tx_pop),
        .flush(w_wr_ctrl & write_data[CTRL_TX_FLUSH]), .din(write_data[7:0]),
        .dout(w_tx_dout), .full(w_tx_full), .empty(w_tx_empty)
    );

    logic [7:0] r_rx_sh;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst), .push(w_rx_push), .pop(w_rx_pop),
        .flush(w_wr_ctrl & write_data[CTRL_RX_FLUSH]), .din(r_rx_sh),
        .dout(w_rx_dout), .full(w_rx_full), .empty(w_rx_empty)
    );

    // Flush bits act as write pulses and are never stored
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ie_rx     <= 1'b0;
            r_ie_tx     <= 1'b0;
            r_loopback  <= 1'b0;
            r_div       <= DEFAULT_DIV;
            r_rx_ovr    <= 1'b0;
            r_tx_drop   <= 1'b0;
            r_frame_err <= 1'b0;
            r_irq       <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_ie_rx    <= write_data[CTRL_IE_RX];
                r_ie_tx    <= write_data[CTRL_IE_TX];
                r_loopback <= write_data[CTRL_LOOPBACK];
            end
            for (int i = 0; i < 4; i++)
                if (w_wr_div && write_mask[i]) r_div[8*i +: 8] <= write_data[8*i +: 8];
            r_rx_ovr    <= (w_rx_push & w_rx_full & ~w_rx_pop) | (r_rx_ovr & ~w_clr[ST_RX_OVR]);
            r_tx_drop   <= (w_wr_data & w_tx_full & ~w_tx_pop) | (r_tx_drop & ~w_clr[ST_TX_DROP]);
            r_frame_err <= w_frame_err_set | (r_frame_err & ~w_clr[ST_FRAME_ERR]);
            r_irq       <= (r_ie_rx & ~w_rx_empty) | (r_ie_tx & w_tx_empty);
        end
    end

    always_comb begin
        w_status               = '0;
        w_status[ST_RX_NE]     = ~w_rx_empty;
        w_status[ST_RX_OVR]    = r_rx_ovr;
        w_status[ST_TX_FULL]   = w_tx_full;
        w_status[ST_RX_FULL]   = w_rx_full;
        w_status[ST_TX_DROP]   = r_tx_drop;
        w_status[ST_TX_EMPTY]  = w_tx_empty;
        w_status[ST_TX_BUSY]   = w_tx_busy;
        w_status[ST_FRAME_ERR] = r_frame_err;
        w_ctrl                 = '0;
        w_ctrl[CTRL_IE_RX]     = r_ie_rx;
        w_ctrl[CTRL_IE_TX]     = r_ie_tx;
        w_ctrl[CTRL_LOOPBACK]  = r_loopback;
        read_data = w_sel_data   ? {24'd0, w_rx_empty ? 8'd0 : w_rx_dout} :
                    w_sel_ctrl   ? {24'd0, w_ctrl} :
                    w_sel_status ? {24'd0, w_status} :
                    w_sel_div    ? r_div : 32'd0;
    end

    tx_state_t   r_tx_state, w_tx_next;
    logic [31:0] r_tx_cnt, r_tx_div;
    logic [2:0]  r_tx_bit;
    logic [7:0]  r_tx_sh;
    logic        w_tx_end;

    assign w_tx_end = r_tx_cnt == r_tx_div - 32'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_tx_state <= TX_IDLE;
        else r_tx_state <= w_tx_next;
    end

    always_comb begin
        w_tx_next = r_tx_state;
        case (r_tx_state)
            TX_IDLE:  if (!w_tx_empty) w_tx_next = TX_START;
            TX_START: if (w_tx_end) w_tx_next = TX_DATA;
            TX_DATA:  if (w_tx_end && r_tx_bit == 3'd7) w_tx_next = TX_STOP;
            TX_STOP:  if (w_tx_end) w_tx_next = w_tx_empty ? TX_IDLE : TX_START;
            default:  w_tx_next = TX_IDLE;
        endcase
    end

    always_comb begin
        tx        = (r_tx_state == TX_START) ? 1'b0 : (r_tx_state == TX_DATA) ? r_tx_sh[0] : 1'b1;
        w_tx_busy = r_tx_state != TX_IDLE;
        w_tx_pop  = ~w_tx_empty & ((r_tx_state == TX_IDLE) | ((r_tx_state == TX_STOP) & w_tx_end));
    end

    // A pop always starts a frame, so it also latches the divisor for that frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_cnt <= '0;
            r_tx_div <= MIN_DIV;
            r_tx_bit <= '0;
            r_tx_sh  <= '0;
        end else begin
            r_tx_cnt <= (r_tx_state == TX_IDLE || w_tx_end) ? 32'd0 : r_tx_cnt + 32'd1;
            if (w_tx_pop) begin
                r_tx_sh  <= w_tx_dout;
                r_tx_div <= eff_div(r_div);
                r_tx_bit <= '0;
            end else if (r_tx_state == TX_DATA && w_tx_end) begin
                r_tx_sh  <= r_tx_sh >> 1;
                r_tx_bit <= r_tx_bit + 3'd1;
            end
        end
    end

    rx_state_t   r_rx_state, w_rx_next;
    logic        r_rx_s1, r_rx_s2, r_rx_prev;
    logic [31:0] r_rx_cnt, r_rx_div;
    logic [2:0]  r_rx_bit;
    logic        w_rx_fall, w_rx_half, w_rx_end, w_rx_tick;

    assign w_rx_fall = r_rx_prev & ~r_rx_s2;
    assign w_rx_half = r_rx_cnt == (r_rx_div >> 1) - 32'd1;
    assign w_rx_end  = r_rx_cnt == r_rx_div - 32'd1;
    assign w_rx_tick = (r_rx_state == RX_START) ? w_rx_half : w_rx_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_rx_state <= RX_IDLE;
        else r_rx_state <= w_rx_next;
    end

    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            RX_IDLE:  if (w_rx_fall) w_rx_next = RX_START;
            RX_START: if (w_rx_half) w_rx_next = r_rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_rx_end && r_rx_bit == 3'd7) w_rx_next = RX_STOP;
            RX_STOP:  if (w_rx_end) w_rx_next = RX_IDLE;
            default:  w_rx_next = RX_IDLE;
        endcase
    end

    always_comb begin
        w_rx_push       = (r_rx_state == RX_STOP) & w_rx_end & r_rx_s2;
        w_frame_err_set = (r_rx_state == RX_STOP) & w_rx_end & ~r_rx_s2;
    end

    // Loopback is muxed ahead of the synchroniser so both sources see identical timing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_s1   <= 1'b1;
            r_rx_s2   <= 1'b1;
            r_rx_prev <= 1'b1;
            r_rx_cnt  <= '0;
            r_rx_div  <= MIN_DIV;
            r_rx_bit  <= '0;
            r_rx_sh   <= '0;
        end else begin
            r_rx_s1   <= r_loopback ? tx : rx;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
            r_rx_cnt  <= (r_rx_state == RX_IDLE || w_rx_tick) ? 32'd0 : r_rx_cnt + 32'd1;
            if (r_rx_state == RX_IDLE) begin
                r_rx_bit <= '0;
                if (w_rx_fall) r_rx_div <= eff_div(r_div);
            end else if (r_rx_state == RX_DATA && w_rx_end) begin
                r_rx_sh  <= {r_rx_s2, r_rx_sh[7:1]};
                r_rx_bit <= r_rx_bit + 3'd1;
            end
        end
    end
endmodule

// File: tb/tb_uart_fifo_mmio.sv
// tb_uart_fifo_mmio: directed stimulus with a scoreboard queue checked by an independent monitor
module tb_uart_fifo_mmio;
    localparam logic [31:0] A_DATA = 32'h10010000;
    localparam logic [31:0] A_CTRL = 32'h10010004;
    localparam logic [31:0] A_STAT = 32'h10010005;
    localparam logic [31:0] A_DIV  = 32'h10010100;
    localparam int K_RD = 0, K_TX = 1, K_IRQ = 2;

    logic        clk, rst, write_enable, read_enable, tx, rx, irq;
    logic [31:0] address, write_data, read_data;
    logic [3:0]  write_mask;
    logic        chk_v;
    int          n_chk, n_fail;
    string       q_name[$];
    int          q_kind[$];
    logic [31:0] q_exp[$];

    uart_fifo_mmio dut (
        .clk(clk), .rst(rst), .address(address), .write_data(write_data),
        .write_mask(write_mask), .write_enable(write_enable), .read_enable(read_enable),
        .read_data(read_data), .tx(tx), .rx(rx), .irq(irq)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin : monitor
        string       nm;
        int          kd;
        logic [31:0] ex, act;
        if (chk_v) begin
            n_chk++;
            if (q_exp.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard: output presented with no expectation queued");
            end else begin
                nm  = q_name.pop_front();
                kd  = q_kind.pop_front();
                ex  = q_exp.pop_front();
                act = (kd == K_RD) ? read_data : (kd == K_TX) ? {31'd0, tx} : {31'd0, irq};
                if (act !== ex) begin
                    n_fail++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, ex, $time);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        address = a; write_data = d; write_mask = m; write_enable = 1;
        tick(1);
        write_enable = 0; address = 0; write_data = 0; write_mask = 0;
    endtask

    task automatic expect_now(input int kd, input logic [31:0] ex, input string nm);
        q_name.push_back(nm); q_kind.push_back(kd); q_exp.push_back(ex);
        chk_v = 1;
        tick(1);
        chk_v = 0;
    endtask

    task automatic rd(input logic [31:0] a, input logic pop, input logic [31:0] ex, input string nm);
        address = a; read_enable = pop;
        expect_now(K_RD, ex, nm);
        read_enable = 0; address = 0;
    endtask

    task automatic rx_byte(input logic [7:0] d, input logic stop);
        rx = 0; tick(4);
        for (int i = 0; i < 8; i++) begin
            rx = d[i]; tick(4);
        end
        rx = stop; tick(4);
        rx = 1; tick(12);
    endtask

    initial begin
        rst = 1; rx = 1; chk_v = 0; n_chk = 0; n_fail = 0;
        address = 0; write_data = 0; write_mask = 0; write_enable = 0; read_enable = 0;
        tick(3);
        expect_now(K_TX, 1, "tx_in_reset");
        rst = 0;
        rd(A_STAT, 0, 32'h20, "reset_status");
        rd(A_DIV, 0, 32'd434, "reset_div");
        rd(A_CTRL, 0, 32'h00, "reset_ctrl");
        rd(A_DATA, 1, 32'h00, "reset_data_empty");
        rd(A_DATA + 32'h200, 0, 32'h0, "outside_window_high");
        rd(A_DATA - 32'h4, 0, 32'h0, "outside_window_low");
        expect_now(K_IRQ, 0, "reset_irq");
        wr(A_DIV, 32'hAABBCCDD, 4'b0101);
        rd(A_DIV, 0, 32'h00BB01DD, "div_byte_mask");

        // Loopback single frame at DIV=4
        wr(A_DIV, 32'd4, 4'hF);
        wr(A_CTRL, 32'h10, 4'h1);
        wr(A_DATA, 32'hA5, 4'h1);
        rd(A_STAT, 0, 32'h00, "t1_status_queued");
        rd(A_STAT, 0, 32'h60, "t1_status_busy");
        expect_now(K_TX, 0, "t1_start_bit");
        tick(3);
        for (int i = 0; i < 8; i++) begin
            expect_now(K_TX, (8'hA5 >> i) & 1, $sformatf("t1_data_bit%0d", i));
            tick(3);
        end
        expect_now(K_TX, 1, "t1_stop_bit");
        rd(A_STAT, 0, 32'h60, "t1_status_last_busy");
        tick(2);
        rd(A_STAT, 0, 32'h21, "t1_status_rx_ready");
        rd(A_DATA, 1, 32'hA5, "t1_rx_data");
        rd(A_STAT, 0, 32'h20, "t1_status_popped");
        rd(A_DATA, 1, 32'h00, "t1_rx_empty_read");

        // TX overflow: engine holds one byte, FIFO holds sixteen, next write drops
        wr(A_CTRL, 32'h00, 4'h1);
        for (int i = 0; i < 17; i++) wr(A_DATA, 32'h40 + i, 4'h1);
        rd(A_STAT, 0, 32'h44, "t2_tx_full");
        wr(A_DATA, 32'hEE, 4'h1);
        rd(A_STAT, 0, 32'h54, "t2_tx_drop");
        wr(A_STAT, 32'h10, 4'h1);
        rd(A_STAT, 0, 32'h44, "t2_drop_cleared");
        wr(A_CTRL, 32'h08, 4'h1);
        rd(A_STAT, 0, 32'h60, "t2_flushed_still_busy");
        rd(A_CTRL, 0, 32'h00, "t2_flush_reads_zero");
        tick(40);
        rd(A_STAT, 0, 32'h20, "t2_idle");

        // RX overrun in loopback
        wr(A_CTRL, 32'h10, 4'h1);
        for (int i = 0; i < 17; i++) wr(A_DATA, 32'h80 + i, 4'h1);
        tick(720);
        rd(A_STAT, 0, 32'h2B, "t3_rx_full_overrun");
        for (int i = 0; i < 16; i++) rd(A_DATA, 1, 32'h80 + i, $sformatf("t3_rx_byte%0d", i));
        rd(A_STAT, 0, 32'h22, "t3_overrun_sticky");
        wr(A_STAT, 32'h02, 4'h1);
        rd(A_STAT, 0, 32'h20, "t3_overrun_cleared");

        // External framing error and glitch rejection
        wr(A_CTRL, 32'h00, 4'h1);
        rx_byte(8'h3C, 0);
        rd(A_STAT, 0, 32'hA0, "t4_frame_err");
        wr(A_STAT, 32'h80, 4'h1);
        rd(A_STAT, 0, 32'h20, "t4_frame_err_cleared");
        rx = 0; tick(1); rx = 1; tick(10);
        rd(A_STAT, 0, 32'h20, "t4_glitch_ignored");
        rx_byte(8'h5A, 1);
        rd(A_STAT, 0, 32'h21, "t4_after_glitch_rx");
        rd(A_DATA, 1, 32'h5A, "t4_rx_data");

        // Interrupts
        wr(A_CTRL, 32'h02, 4'h1);
        expect_now(K_IRQ, 0, "t5_irq_lag");
        expect_now(K_IRQ, 1, "t5_irq_tx_empty");
        wr(A_DATA, 32'h55, 4'h1);
        expect_now(K_IRQ, 1, "t5_irq_before_fall");
        expect_now(K_IRQ, 0, "t5_irq_tx_nonempty");
        expect_now(K_IRQ, 1, "t5_irq_after_pop");
        wr(A_CTRL, 32'h01, 4'h1);
        expect_now(K_IRQ, 1, "t5_irq_ie_switch_lag");
        expect_now(K_IRQ, 0, "t5_irq_rx_empty");
        tick(45);
        rx_byte(8'h96, 1);
        expect_now(K_IRQ, 1, "t5_irq_rx_ready");
        rd(A_DATA, 1, 32'h96, "t5_rx_data");
        expect_now(K_IRQ, 1, "t5_irq_pop_lag");
        expect_now(K_IRQ, 0, "t5_irq_rx_drained");
        wr(A_CTRL, 32'h00, 4'h1);

        // Reset in the middle of a data bit
        wr(A_DIV, 32'd4, 4'hF);
        wr(A_DATA, 32'h00, 4'h1);
        tick(6);
        expect_now(K_TX, 0, "t6_mid_data_low");
        rst = 1;
        expect_now(K_TX, 1, "t6_tx_async_reset");
        rst = 0;
        rd(A_DIV, 0, 32'd434, "t6_div_reset");
        rd(A_STAT, 0, 32'h20, "t6_status_reset");
        rd(A_CTRL, 0, 32'h00, "t6_ctrl_reset");

        // DIV=1 runs as 2: 20-clock frame
        wr(A_DIV, 32'd1, 4'hF);
        wr(A_CTRL, 32'h10, 4'h1);
        wr(A_DATA, 32'h3C, 4'h1);
        tick(20);
        rd(A_STAT, 0, 32'h60, "t7_div1_last_busy");
        rd(A_STAT, 0, 32'h20, "t7_div1_done");
        tick(2);
        rd(A_STAT, 0, 32'h21, "t7_div1_rx_ready");
        rd(A_DATA, 1, 32'h3C, "t7_div1_rx_data");

        tick(2);
        n_chk++;
        if (q_exp.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q_exp.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
